// File: rtl/seg_scan_driver.sv
// Four-digit 7-segment scan controller. It cycles through the digits at a
// programmable rate and latches the shown value only at frame boundaries, so a frame never mixes two values.
module seg_scan_driver #(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] value,
    input  logic        load,
    input  logic        lz_en,
    output logic [1:0]  sel,
    output logic [3:0]  bcd,
    output logic        digit_blank,
    output logic        frame_done
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(REFRESH_DIV - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_sel;
    logic [15:0]      r_shadow;
    logic [15:0]      r_disp;
    logic             r_frame_done;

    logic             w_tc;
    logic             w_wrap;
    logic             w_upper_zero;
    logic [3:0]       w_nibble;

    assign w_tc   = (r_cnt == TC_VAL);
    assign w_wrap = w_tc && (r_sel == 2'd3);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_cnt        <= '0;
            r_sel        <= '0;
            r_shadow     <= '0;
            r_disp       <= '0;
            r_frame_done <= 1'b0;
        end else begin
            if (w_tc) begin
                r_cnt <= '0;
                r_sel <= r_sel + 2'd1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (load) begin
                r_shadow <= value;
            end

            // A load landing on the wrap edge bypasses the shadow so it shows this frame.
            if (w_wrap) begin
                r_disp <= load ? value : r_shadow;
            end

            r_frame_done <= w_wrap;
        end
    end

    always_comb begin
        w_nibble     = r_disp[3:0];
        w_upper_zero = 1'b0;
        case (r_sel)
            2'd0: begin
                w_nibble     = r_disp[3:0];
                w_upper_zero = (r_disp == 16'h0000);
            end
            2'd1: begin
                w_nibble     = r_disp[7:4];
                w_upper_zero = (r_disp[15:4] == 12'h000);
            end
            2'd2: begin
                w_nibble     = r_disp[11:8];
                w_upper_zero = (r_disp[15:8] == 8'h00);
            end
            default: begin
                w_nibble     = r_disp[15:12];
                w_upper_zero = (r_disp[15:12] == 4'h0);
            end
        endcase
    end

    assign sel         = r_sel;
    assign bcd         = w_nibble;
    assign digit_blank = lz_en && (r_sel != 2'd0) && w_upper_zero;
    assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed scenarios followed by random traffic.
// All outputs are checked every cycle against a time-based reference model.
module tb_seg_scan_driver;

    localparam int unsigned DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value = '0;
    logic        load = 1'b0;
    logic        lz_en = 1'b0;
    logic [1:0]  sel;
    logic [3:0]  bcd;
    logic        digit_blank;
    logic        frame_done;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference state: cycles since reset, pending and displayed values.
    int unsigned m_t = 0;
    logic [15:0] m_shadow = '0;
    logic [15:0] m_disp = '0;
    logic        m_fd = 1'b0;

    seg_scan_driver #(.REFRESH_DIV(DIV), .CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .value      (value),
        .load       (load),
        .lz_en      (lz_en),
        .sel        (sel),
        .bcd        (bcd),
        .digit_blank(digit_blank),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic int unsigned m_sel();
        return (m_t / DIV) % 4;
    endfunction

    function automatic int unsigned m_pos();
        return m_t % (4 * DIV);
    endfunction

    task automatic check_outputs();
        int unsigned s;
        logic [3:0]  exp_bcd;
        logic        exp_blank;
        s         = m_sel();
        exp_bcd   = 4'((m_disp >> (4 * s)) & 16'hF);
        exp_blank = lz_en && (s != 0) && ((m_disp >> (4 * s)) == 16'h0);
        checks++;
        assert (sel === 2'(s)) else begin
            errors++;
            $error("FAIL sel: got %0d expected %0d (t=%0d)", sel, s, m_t);
        end
        checks++;
        assert (bcd === exp_bcd) else begin
            errors++;
            $error("FAIL bcd: got %h expected %h (t=%0d disp=%h)", bcd, exp_bcd, m_t, m_disp);
        end
        checks++;
        assert (digit_blank === exp_blank) else begin
            errors++;
            $error("FAIL digit_blank: got %b expected %b (t=%0d disp=%h lz=%b)",
                   digit_blank, exp_blank, m_t, m_disp, lz_en);
        end
        checks++;
        assert (frame_done === m_fd) else begin
            errors++;
            $error("FAIL frame_done: got %b expected %b (t=%0d)", frame_done, m_fd, m_t);
        end
    endtask

    // One clock: model consumes the inputs held across the edge, outputs checked at negedge.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            m_t      = 0;
            m_shadow = '0;
            m_disp   = '0;
            m_fd     = 1'b0;
        end else begin
            m_fd = (m_pos() == 4 * DIV - 1);
            if (m_fd) m_disp = load ? value : m_shadow;
            if (load) m_shadow = value;
            m_t++;
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic load_once(input logic [15:0] v);
        value = v;
        load  = 1'b1;
        tick();
        load  = 1'b0;
    endtask

    task automatic run_until_pos(input int unsigned p);
        for (int unsigned i = 0; i < 4 * DIV && m_pos() != p; i++) tick();
        checks++;
        assert (m_pos() == p) else begin
            errors++;
            $error("FAIL run_until_pos: got %0d expected %0d", m_pos(), p);
        end
    endtask

    initial begin
        // Reset held two cycles.
        reset_n = 1'b0;
        run(2);
        reset_n = 1'b1;

        // Scan 16'h1234 through two frames.
        load_once(16'h1234);
        run(32);

        // Load mid-frame at sel=1; must not appear until the wrap.
        run_until_pos(DIV);
        load_once(16'hABCD);
        run(20);

        // Load exactly on the sel=3 terminal count.
        run_until_pos(4 * DIV - 1);
        load_once(16'h00F0);
        checks++;
        assert (m_disp == 16'h00F0) else begin
            errors++;
            $error("FAIL collision_model: got %h expected %h", m_disp, 16'h00F0);
        end

        // Leading-zero blanking on 00F0, then on 0000, then disabled.
        lz_en = 1'b1;
        run(16);
        load_once(16'h0000);
        run(32);
        lz_en = 1'b0;
        run(16);

        // Reset mid-frame at sel=2, count=2.
        load_once(16'h5A3C);
        run(16);
        run_until_pos(2 * DIV + 2);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        load_once(16'h0807);
        lz_en = 1'b1;
        run(24);

        // Random traffic with occasional resets.
        for (int unsigned i = 0; i < 600; i++) begin
            value   = 16'($urandom);
            load    = ($urandom_range(0, 7) == 0);
            lz_en   = ($urandom_range(0, 3) != 0);
            reset_n = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 3) == 0) value = value & 16'h00FF;
            tick();
        end
        reset_n = 1'b1;
        load    = 1'b0;
        run(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
